dds_sweep_ctrl: RTL and testbench
=================================

# dds_sweep_ctrl

Frequency-sweep sequencer for the DDS phase accumulator. It latches a start/stop/step tuning-word configuration and steps the accumulator's frequency word from start toward stop. Each word is held for a programmable dwell time. Start/busy/done handshaking lets the system controller launch and monitor sweeps. It sits between the control registers and the tuning-word input of the accumulator, whose state flip-flops share the same CLK and CLRbar.

## Interface
- FW_W, 16, tuning-word width
- DWELL_W, 12, dwell-counter width
- CLK  input  1  system clock, all state updates on rising edge
- CLRbar  input  1  reset, asynchronous, active-high (1 = clear)
- start  input  1  launch sweep; sampled only in IDLE
- abort  input  1  terminate sweep; sampled in RUN and IDLE
- start_fw  input  FW_W  first tuning word (unsigned)
- stop_fw  input  FW_W  upper bound tuning word (unsigned, inclusive)
- step_fw  input  FW_W  increment per step (unsigned, nonzero)
- dwell  input  DWELL_W  hold time per word = dwell+1 cycles
- fw_out  output  FW_W  tuning word to phase accumulator, registered
- fw_load  output  1  one-cycle pulse, high in first cycle each fw_out word is valid
- busy  output  1  high while sweeping
- done  output  1  one-cycle pulse after the final word's dwell expires
- err  output  1  one-cycle pulse on rejected configuration

## Operation
- States: IDLE, RUN. done and err are registered pulses, not states.
- IDLE, start=1, abort=0, config valid:
  - latch start_fw/stop_fw/step_fw/dwell into shadow registers
  - fw_out <= start_fw, fw_load <= 1, busy <= 1
  - dwell counter <= dwell, direction <= up
  - go to RUN
- Config invalid if step_fw==0 or start_fw>stop_fw: err <= 1 for one cycle, stay IDLE, fw_out unchanged.
- Input changes after latch have no effect until the next start.
- RUN, counter>0: counter decrements; fw_out holds.
- RUN, counter==0 (up direction):
  - compute next = fw_out + step in FW_W+1 bits; no wrap-around
  - if next <= stop: fw_out <= next[FW_W-1:0], fw_load <= 1, counter <= dwell
  - else the sweep ends: busy <= 0, done <= 1, go to IDLE; fw_out holds the last word until the next start
- The last word is the largest start + k·step that is <= stop. stop_fw itself is emitted only if reached exactly.
- abort=1 in RUN: next edge goes to IDLE, busy <= 0, no done, fw_out holds. Abort beats a step or finish on the same edge.
- start while busy: ignored. start and abort both high in IDLE: abort wins, no launch.
- done and start in the same cycle: a new sweep may launch on the cycle after done.
- Reset (asynchronous, any state): state IDLE, fw_out=0, fw_load=0, busy=0, done=0, err=0, counter=0, direction=up.

## Timing
- start sampled at edge N. After N: busy=1, fw_out=start_fw, fw_load=1.
- Each word is valid for exactly dwell+1 cycles, beginning with its fw_load cycle.
- A sweep of W words keeps busy high for W·(dwell+1) cycles. done is high in the cycle immediately after the last busy cycle, with busy=0.
- err is high the cycle after the sampling edge.
- Abort at edge M: busy=0 from after M.
- fw_load never occurs in the same cycle as done.

## Configuration
- Macro DDS_SWEEP_PINGPONG_EN.
- Undefined: one-shot sweep as above.
- Defined: continuous triangular sweep.
  - At the upper bound (next > stop), direction flips to down and fw_out <= fw_out − step; the endpoint word is not repeated.
  - Down direction: compute fw_out − step with a borrow bit. If the result is < start, flip to up and emit fw_out + step.
  - If only one word fits (start + step > stop), that word is re-emitted with fw_load every dwell+1 cycles.
  - done never asserts; only abort or reset ends the sweep.
  - Invalid-config checking is unchanged.

## Test plan
- Exact endpoint: start=100, stop=130, step=10, dwell=2 → fw_out 100,110,120,130, each 3 cycles, 4 fw_load pulses. busy high 12 cycles, then done=1 for 1 cycle. fw_out stays 130.
- Non-exact endpoint with overflow: start=100, stop=125, step=10, dwell=0 → 100,110,120, one cycle each, done on cycle 4. Separately, FW_W=16, start=0xFFF0, stop=0xFFFF, step=0x0008 → 0xFFF0, 0xFFF8, then done with no wrap to 0x0000.
- Invalid config: step=0 with start pulse → err=1 for one cycle, busy=0, fw_out unchanged. Same result for start=50, stop=40.
- Abort and ignored start: abort at cycle 5 of the first test → busy=0 next cycle, no done, fw_out=110. start asserted while busy → no change to the sweep sequence.
- Reset mid-sweep: CLRbar=1 asynchronously, between clock edges, during RUN → all outputs 0 immediately, no done. A restart after release begins again from start_fw.
- PINGPONG_EN, start=100, stop=130, step=10, dwell=1 → 100,110,120,130,120,110,100,110…, each 2 cycles, done never asserts. abort → busy=0.

Source files
------------

// File: rtl/dds_sweep_ctrl_if.sv
// Control/status bundle between the register block and dds_sweep_ctrl.
// master drives the sweep configuration; slave is the sequencer.
interface dds_sweep_ctrl_if #(
    parameter int unsigned FW_W    = 16,
    parameter int unsigned DWELL_W = 12
);
    logic               start;
    logic               abort;
    logic [FW_W-1:0]    start_fw;
    logic [FW_W-1:0]    stop_fw;
    logic [FW_W-1:0]    step_fw;
    logic [DWELL_W-1:0] dwell;
    logic [FW_W-1:0]    fw_out;
    logic               fw_load;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, abort, start_fw, stop_fw, step_fw, dwell,
        input  fw_out, fw_load, busy, done, err
    );

    modport slave (
        input  start, abort, start_fw, stop_fw, step_fw, dwell,
        output fw_out, fw_load, busy, done, err
    );
endinterface

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer: steps fw_out from start_fw toward stop_fw, dwell+1 cycles per word.
// Define DDS_SWEEP_PINGPONG_EN for a continuous triangular sweep instead of a one-shot ramp.
module dds_sweep_ctrl #(
    parameter int unsigned FW_W    = 16,
    parameter int unsigned DWELL_W = 12
) (
    input logic             CLK,
    input logic             CLRbar,
    dds_sweep_ctrl_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q;
    logic [FW_W-1:0]    fw_q;
    logic               load_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [FW_W-1:0]    stop_q;
    logic [FW_W-1:0]    step_q;
    logic [DWELL_W-1:0] dwell_q;

    logic [FW_W:0]      up_next;
    logic               up_ok;
    logic               cfg_ok;

    // Extra carry bit keeps an overflowing step from wrapping below stop.
    assign up_next = {1'b0, fw_q} + {1'b0, step_q};
    assign up_ok   = (up_next <= {1'b0, stop_q});
    assign cfg_ok  = (bus.step_fw != '0) && (bus.start_fw <= bus.stop_fw);

`ifdef DDS_SWEEP_PINGPONG_EN
    logic [FW_W-1:0]    start_q;
    logic               dir_up_q;
    logic [FW_W:0]      dn_next;
    logic               dn_ok;

    assign dn_next = {1'b0, fw_q} - {1'b0, step_q};
    assign dn_ok   = !dn_next[FW_W] && (dn_next[FW_W-1:0] >= start_q);
`endif

    always_ff @(posedge CLK or posedge CLRbar) begin
        if (CLRbar) begin
            state_q  <= StIdle;
            fw_q     <= '0;
            load_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            stop_q   <= '0;
            step_q   <= '0;
            dwell_q  <= '0;
`ifdef DDS_SWEEP_PINGPONG_EN
            start_q  <= '0;
            dir_up_q <= 1'b1;
`endif
        end else begin
            load_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start && !bus.abort) begin
                        if (!cfg_ok) begin
                            err_q <= 1'b1;
                        end else begin
                            stop_q   <= bus.stop_fw;
                            step_q   <= bus.step_fw;
                            dwell_q  <= bus.dwell;
                            fw_q     <= bus.start_fw;
                            cnt_q    <= bus.dwell;
                            load_q   <= 1'b1;
                            busy_q   <= 1'b1;
`ifdef DDS_SWEEP_PINGPONG_EN
                            start_q  <= bus.start_fw;
                            dir_up_q <= 1'b1;
`endif
                            state_q  <= StRun;
                        end
                    end
                end
                StRun: begin
                    if (bus.abort) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - DWELL_W'(1);
                    end else begin
`ifdef DDS_SWEEP_PINGPONG_EN
                        // If neither direction fits, the single word is re-emitted.
                        load_q <= 1'b1;
                        cnt_q  <= dwell_q;
                        if (dir_up_q) begin
                            if (up_ok) begin
                                fw_q <= up_next[FW_W-1:0];
                            end else if (dn_ok) begin
                                dir_up_q <= 1'b0;
                                fw_q     <= dn_next[FW_W-1:0];
                            end
                        end else begin
                            if (dn_ok) begin
                                fw_q <= dn_next[FW_W-1:0];
                            end else if (up_ok) begin
                                dir_up_q <= 1'b1;
                                fw_q     <= up_next[FW_W-1:0];
                            end
                        end
`else
                        if (up_ok) begin
                            fw_q   <= up_next[FW_W-1:0];
                            load_q <= 1'b1;
                            cnt_q  <= dwell_q;
                        end else begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.fw_out  = fw_q;
    assign bus.fw_load = load_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: table of sweep configurations plus abort/reset sequences.
// Follows DDS_SWEEP_PINGPONG_EN to select one-shot or triangular expectations.
module tb_dds_sweep_ctrl;
    localparam int unsigned FW_W    = 16;
    localparam int unsigned DWELL_W = 12;

    logic CLK    = 1'b0;
    logic CLRbar = 1'b1;
    always #5 CLK = ~CLK;

    dds_sweep_ctrl_if #(.FW_W(FW_W), .DWELL_W(DWELL_W)) bus ();

    dds_sweep_ctrl #(.FW_W(FW_W), .DWELL_W(DWELL_W)) dut (
        .CLK    (CLK),
        .CLRbar (CLRbar),
        .bus    (bus.slave)
    );

    typedef struct {
        logic [15:0] s;
        logic [15:0] p;
        logic [15:0] st;
        logic [11:0] d;
        int          nwords;
        logic [15:0] last;
        bit          err;
        bit          poke;
    } vec_t;

    vec_t        tbl [8];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] prev_fw = 16'd0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pulse start with a config, then scramble inputs to prove they were latched.
    task automatic launch(input logic [15:0] s, input logic [15:0] p, input logic [15:0] st,
                          input logic [11:0] d);
        bus.start_fw = s;
        bus.stop_fw  = p;
        bus.step_fw  = st;
        bus.dwell    = d;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.start_fw = 16'h0003;
        bus.stop_fw  = 16'h0004;
        bus.step_fw  = 16'h0000;
        bus.dwell    = 12'hFFF;
    endtask

    // Cycle c of a ramp shows word s + (c / (d+1)) * st, with fw_load on its first cycle.
    task automatic expect_ramp(input logic [15:0] s, input logic [15:0] st, input logic [11:0] d,
                               input int c0, input int c1);
        int          dw;
        logic [31:0] e;
        dw = int'(d) + 1;
        for (int c = c0; c < c1; c++) begin
            e = 32'(s) + 32'(st) * 32'(c / dw);
            check("ramp_busy", 32'(bus.busy), 32'd1);
            check("ramp_fw_out", 32'(bus.fw_out), {16'd0, e[15:0]});
            check("ramp_fw_load", 32'(bus.fw_load), 32'((c % dw) == 0));
            check("ramp_done", 32'(bus.done), 32'd0);
            tick();
        end
    endtask

    task automatic expect_done(input logic [15:0] last);
        check("end_busy", 32'(bus.busy), 32'd0);
        check("end_done", 32'(bus.done), 32'd1);
        check("end_fw_load", 32'(bus.fw_load), 32'd0);
        check("end_fw_out", 32'(bus.fw_out), 32'(last));
        tick();
        check("post_done", 32'(bus.done), 32'd0);
        check("post_fw_out", 32'(bus.fw_out), 32'(last));
    endtask

    task automatic expect_err(input logic [15:0] keep);
        check("err_pulse", 32'(bus.err), 32'd1);
        check("err_busy", 32'(bus.busy), 32'd0);
        check("err_fw_load", 32'(bus.fw_load), 32'd0);
        check("err_fw_out", 32'(bus.fw_out), 32'(keep));
        tick();
        check("err_clear", 32'(bus.err), 32'd0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.start_fw = '0;
        bus.stop_fw  = '0;
        bus.step_fw  = '0;
        bus.dwell    = '0;

        tbl[0] = '{s: 16'd100,   p: 16'd130,   st: 16'd10,    d: 12'd2, nwords: 4,
                   last: 16'd130,   err: 1'b0, poke: 1'b0};
        tbl[1] = '{s: 16'd100,   p: 16'd125,   st: 16'd10,    d: 12'd0, nwords: 3,
                   last: 16'd120,   err: 1'b0, poke: 1'b0};
        tbl[2] = '{s: 16'd10,    p: 16'd20,    st: 16'd0,     d: 12'd1, nwords: 0,
                   last: 16'd0,     err: 1'b1, poke: 1'b0};
        tbl[3] = '{s: 16'd50,    p: 16'd40,    st: 16'd5,     d: 12'd1, nwords: 0,
                   last: 16'd0,     err: 1'b1, poke: 1'b0};
        tbl[4] = '{s: 16'hFFF0,  p: 16'hFFFF,  st: 16'h0008,  d: 12'd0, nwords: 2,
                   last: 16'hFFF8,  err: 1'b0, poke: 1'b0};
        tbl[5] = '{s: 16'd7,     p: 16'd7,     st: 16'd3,     d: 12'd1, nwords: 1,
                   last: 16'd7,     err: 1'b0, poke: 1'b0};
        tbl[6] = '{s: 16'd0,     p: 16'hFFFF,  st: 16'hFFFF,  d: 12'd0, nwords: 2,
                   last: 16'hFFFF,  err: 1'b0, poke: 1'b0};
        tbl[7] = '{s: 16'd100,   p: 16'd130,   st: 16'd10,    d: 12'd2, nwords: 4,
                   last: 16'd130,   err: 1'b0, poke: 1'b1};

        // Reset state
        #12;
        check("rst_fw_out", 32'(bus.fw_out), 32'd0);
        check("rst_fw_load", 32'(bus.fw_load), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        #11;
        CLRbar = 1'b0;
        tick();

`ifndef DDS_SWEEP_PINGPONG_EN
        for (int i = 0; i < 8; i++) begin
            launch(tbl[i].s, tbl[i].p, tbl[i].st, tbl[i].d);
            if (tbl[i].err) begin
                expect_err(prev_fw);
            end else begin
                if (tbl[i].poke) begin
                    expect_ramp(tbl[i].s, tbl[i].st, tbl[i].d, 0, 1);
                    bus.start    = 1'b1;
                    bus.start_fw = 16'd5;
                    bus.stop_fw  = 16'hFFFF;
                    bus.step_fw  = 16'd1;
                    expect_ramp(tbl[i].s, tbl[i].st, tbl[i].d, 1, 3);
                    bus.start    = 1'b0;
                    expect_ramp(tbl[i].s, tbl[i].st, tbl[i].d, 3,
                                tbl[i].nwords * (int'(tbl[i].d) + 1));
                end else begin
                    expect_ramp(tbl[i].s, tbl[i].st, tbl[i].d, 0,
                                tbl[i].nwords * (int'(tbl[i].d) + 1));
                end
                expect_done(tbl[i].last);
                prev_fw = tbl[i].last;
            end
        end
`endif

        // Abort at cycle 5 of the 100..130 sweep
        launch(16'd100, 16'd130, 16'd10, 12'd2);
        expect_ramp(16'd100, 16'd10, 12'd2, 0, 5);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_fw_out", 32'(bus.fw_out), 32'd110);
        check("abort_done", 32'(bus.done), 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("abort_idle_done", 32'(bus.done), 32'd0);
            check("abort_idle_load", 32'(bus.fw_load), 32'd0);
            check("abort_idle_fw", 32'(bus.fw_out), 32'd110);
        end

        // start and abort together in IDLE: no launch
        bus.start_fw = 16'd100;
        bus.stop_fw  = 16'd130;
        bus.step_fw  = 16'd10;
        bus.dwell    = 12'd2;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("sa_busy", 32'(bus.busy), 32'd0);
        check("sa_fw_load", 32'(bus.fw_load), 32'd0);
        check("sa_fw_out", 32'(bus.fw_out), 32'd110);

        // Asynchronous reset between edges while a word is loading
        launch(16'd200, 16'd260, 16'd20, 12'd1);
        expect_ramp(16'd200, 16'd20, 12'd1, 0, 2);
        #2;
        CLRbar = 1'b1;
        #1;
        check("arst_fw_out", 32'(bus.fw_out), 32'd0);
        check("arst_fw_load", 32'(bus.fw_load), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_err", 32'(bus.err), 32'd0);
        tick();
        CLRbar = 1'b0;
        tick();
        check("arst_after_busy", 32'(bus.busy), 32'd0);
        check("arst_after_done", 32'(bus.done), 32'd0);
        launch(16'd200, 16'd260, 16'd20, 12'd1);
        expect_ramp(16'd200, 16'd20, 12'd1, 0, 8);
`ifndef DDS_SWEEP_PINGPONG_EN
        expect_done(16'd260);
`else
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("relaunch_abort_busy", 32'(bus.busy), 32'd0);

        begin
            int pp_seq [11] = '{100, 110, 120, 130, 120, 110, 100, 110, 120, 130, 120};
            launch(16'd100, 16'd130, 16'd10, 12'd1);
            for (int c = 0; c < 22; c++) begin
                check("pp_fw_out", 32'(bus.fw_out), 32'(pp_seq[c / 2]));
                check("pp_fw_load", 32'(bus.fw_load), 32'((c % 2) == 0));
                check("pp_busy", 32'(bus.busy), 32'd1);
                check("pp_done", 32'(bus.done), 32'd0);
                tick();
            end
            bus.abort = 1'b1;
            tick();
            bus.abort = 1'b0;
            check("pp_abort_busy", 32'(bus.busy), 32'd0);
            check("pp_abort_fw", 32'(bus.fw_out), 32'd110);
            check("pp_abort_done", 32'(bus.done), 32'd0);
        end

        // Single word fits: re-emitted every dwell+1 cycles
        launch(16'd7, 16'd7, 16'd3, 12'd1);
        for (int c = 0; c < 8; c++) begin
            check("pp1_fw_out", 32'(bus.fw_out), 32'd7);
            check("pp1_fw_load", 32'(bus.fw_load), 32'((c % 2) == 0));
            check("pp1_busy", 32'(bus.busy), 32'd1);
            tick();
        end
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("pp1_abort_busy", 32'(bus.busy), 32'd0);

        launch(16'd10, 16'd20, 16'd0, 12'd0);
        expect_err(16'd7);
        launch(16'd50, 16'd40, 16'd5, 12'd0);
        expect_err(16'd7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
